seg_scan_scheduler: RTL and testbench
=====================================

SEG_SCAN_SCHEDULER -- requirements
Module: seg_scan_scheduler

Interface
REQ-001 The block SHALL have parameter TICK_DIV, default 100000, clock cycles per scan tick (>=2).
REQ-002 The block SHALL have parameter DIGIT_TICKS, default 4, ticks each digit is lit (>=1).
REQ-003 The block SHALL have parameter BLINK_FRAMES, default 125, frames per blink half-period (>=1).
REQ-004 The block SHALL have port clk  input  1  the single clock.
REQ-005 The block SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 The block SHALL have port en  input  1  scan enable; low forces IDLE.
REQ-007 The block SHALL have port blink  input  1  high enables blinking of both digits.
REQ-008 The block SHALL have port sel  output  1  select to the shared 7-bit segment mux; 0 picks digit 0 pattern, 1 picks digit 1.
REQ-009 The block SHALL have port an  output  2  digit anodes, active-low; an[0] digit 0, an[1] digit 1.
REQ-010 The block SHALL have port frame_done  output  1  one-cycle pulse at end of each full scan frame.
REQ-011 The block SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-012 The FSM SHALL have states IDLE, SHOW0, GAP0, SHOW1, GAP1.
REQ-013 IDLE -> SHOW0 SHALL occur on the first clock with en=1; the tick counter SHALL restart at 0 on this transition.
REQ-014 The tick generator SHALL count 0..TICK_DIV-1 outside IDLE and assert an internal tick in the cycle the count equals TICK_DIV-1, then wrap to 0.
REQ-015 SHOW0 and SHOW1 SHALL each last exactly DIGIT_TICKS ticks; GAP0 and GAP1 SHALL each last exactly 1 tick.
REQ-016 The order SHALL be SHOW0 -> GAP0 -> SHOW1 -> GAP1 -> SHOW0, continuously while en=1; one frame = (2*DIGIT_TICKS+2)*TICK_DIV cycles.
REQ-017 All outputs SHALL be registered; an SHALL be 2'b10 in SHOW0, 2'b01 in SHOW1, 2'b11 in IDLE, GAP0, GAP1.
REQ-018 sel SHALL change only on the GAP0->... boundaries inside a gap: sel SHALL go to 1 on entry to GAP0 and to 0 on entry to GAP1, so sel is stable for the entire SHOW state that follows (anti-ghosting).
REQ-019 frame_done SHALL pulse high for exactly the one cycle following the GAP1 -> SHOW0 transition.
REQ-020 A frame counter SHALL count 0..BLINK_FRAMES-1 on each frame_done and wrap, toggling an internal blink phase on wrap.
REQ-021 When blink=1 and blink phase=1, an SHALL be forced to 2'b11 while FSM timing, sel and frame_done continue unchanged.
REQ-022 When blink=0, the blink phase and frame counter SHALL be held at 0.
REQ-023 en deasserted in any state SHALL move the FSM to IDLE on the next clock, with an=2'b11, sel=0, tick, frame and phase counters cleared; no frame_done SHALL be emitted for the aborted frame.
REQ-024 Counter widths SHALL be $clog2 of their terminal values (min 1 bit); no counter SHALL exceed its terminal value.

Reset
REQ-025 Asynchronous rst=1 SHALL immediately force state IDLE, sel=0, an=2'b11, frame_done=0, busy=0 and all counters and blink phase to 0.
REQ-026 After rst deasserts, behaviour SHALL be identical to a fresh IDLE with en sampled on the next clock edge.

Structure
REQ-027 The shared package SHALL hold the FSM state enum and the anode encodings AN_OFF=2'b11, AN_D0=2'b10, AN_D1=2'b01.
REQ-028 The tick generator SHALL be a sub-module named scan_tick_gen with parameter TICK_DIV, inputs clk, rst, clear, output tick.

Verification (bench: TICK_DIV=4, DIGIT_TICKS=2, BLINK_FRAMES=2; 24-cycle frame)
REQ-029 rst then en=1 held -> an=10 cycles 1-8, 11 cycles 9-12 with sel=1 from cycle 9, 01 cycles 13-20, 11 cycles 21-24 with sel=0 from cycle 21, frame_done one cycle at cycle 25.
REQ-030 blink=1 for 6 frames -> frames 1-2 lit normally, frames 3-4 an=11 throughout, frames 5-6 lit; frame_done every 24 cycles throughout.
REQ-031 en dropped mid-SHOW1 -> next cycle an=11, sel=0, busy=0; no frame_done; re-raising en restarts at SHOW0 with full 8-cycle duration.
REQ-032 rst asserted asynchronously mid-GAP0 -> outputs reach reset values before the next clock edge; restart timing matches REQ-029.
REQ-033 Assertion over all runs: an never equals 2'b00; sel never changes while an differs from 2'b11.

Source files
------------

// File: rtl/seg_scan_scheduler_pkg.sv
// Shared definitions for the two-digit 7-segment scan scheduler.
// Holds the FSM state encodings, the active-low anode patterns and a helper
// that maps a scan state to the anode pattern it should drive.
package seg_scan_scheduler_pkg;

    typedef logic [2:0] state_t;
    typedef logic [1:0] an_t;

    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_SHOW0 = 3'd1;
    localparam state_t ST_GAP0  = 3'd2;
    localparam state_t ST_SHOW1 = 3'd3;
    localparam state_t ST_GAP1  = 3'd4;

    localparam an_t AN_OFF = 2'b11;
    localparam an_t AN_D0  = 2'b10;
    localparam an_t AN_D1  = 2'b01;

    function automatic an_t an_for_state(input state_t s);
        case (s)
            ST_SHOW0: return AN_D0;
            ST_SHOW1: return AN_D1;
            default:  return AN_OFF;
        endcase
    endfunction

endpackage

// File: rtl/seg_scan_scheduler_if.sv
// Control/status bundle of the scan scheduler.
//   en, blink        : scan enable and blink enable (master -> slave)
//   sel              : segment mux select (slave -> master)
//   an               : active-low digit anodes (slave -> master)
//   frame_done, busy : frame-end pulse and non-idle status (slave -> master)
interface seg_scan_scheduler_if;
    import seg_scan_scheduler_pkg::*;

    logic en;
    logic blink;
    logic sel;
    an_t  an;
    logic frame_done;
    logic busy;

    modport master (output en, blink, input sel, an, frame_done, busy);
    modport slave  (input en, blink, output sel, an, frame_done, busy);
endinterface

// File: rtl/seg_scan_scheduler_tick_gen.sv
// Scan tick generator: free-running divider counting 0..TICK_DIV-1.
//   clk, rst : clock and asynchronous active-high reset
//   clear    : synchronous restart of the count at 0
//   tick     : high during the cycle the count equals TICK_DIV-1
module scan_tick_gen #(
    parameter int unsigned TICK_DIV = 100000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);
    localparam int unsigned CW = ($clog2(TICK_DIV) > 0) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clear || cnt_q == LAST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    assign tick = (cnt_q == LAST);
endmodule

// File: rtl/seg_scan_scheduler.sv
// Two-digit multiplexed 7-segment scan scheduler.
// Cycles SHOW0 -> GAP0 -> SHOW1 -> GAP1 while enabled, blanking both anodes
// in the gaps so the shared segment select can switch without ghosting.
//   clk, rst : clock and asynchronous active-high reset
//   bus      : en/blink in; sel, an, frame_done, busy out (all registered)
module seg_scan_scheduler
    import seg_scan_scheduler_pkg::*;
#(
    parameter int unsigned TICK_DIV     = 100000,
    parameter int unsigned DIGIT_TICKS  = 4,
    parameter int unsigned BLINK_FRAMES = 125
) (
    input logic                 clk,
    input logic                 rst,
    seg_scan_scheduler_if.slave bus
);
    localparam int unsigned DW = ($clog2(DIGIT_TICKS) > 0) ? $clog2(DIGIT_TICKS) : 1;
    localparam int unsigned FW = ($clog2(BLINK_FRAMES) > 0) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [DW-1:0] DLAST = DW'(DIGIT_TICKS - 1);
    localparam logic [FW-1:0] FLAST = FW'(BLINK_FRAMES - 1);

    state_t        state_q, state_d;
    logic [DW-1:0] dcnt_q, dcnt_d;
    logic [FW-1:0] fcnt_q, fcnt_d;
    logic          phase_q, phase_d;
    logic          sel_q, sel_d;
    an_t           an_q, an_d;
    logic          fd_q, busy_q;
    logic          frame_evt;
    logic          tick;

    // Restarting in IDLE makes the first SHOW0 tick a full TICK_DIV cycles.
    scan_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk   (clk),
        .rst   (rst),
        .clear (!bus.en || state_q == ST_IDLE),
        .tick  (tick)
    );

    always_comb begin
        state_d   = state_q;
        dcnt_d    = dcnt_q;
        frame_evt = 1'b0;
        if (!bus.en) begin
            state_d = ST_IDLE;
            dcnt_d  = '0;
        end else begin
            case (state_q)
                ST_IDLE: state_d = ST_SHOW0;
                ST_SHOW0, ST_SHOW1: begin
                    if (tick) begin
                        if (dcnt_q == DLAST) begin
                            dcnt_d  = '0;
                            state_d = (state_q == ST_SHOW0) ? ST_GAP0 : ST_GAP1;
                        end else begin
                            dcnt_d = dcnt_q + DW'(1);
                        end
                    end
                end
                ST_GAP0: if (tick) state_d = ST_SHOW1;
                ST_GAP1: begin
                    if (tick) begin
                        state_d   = ST_SHOW0;
                        frame_evt = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        // Blink phase advances on the same edge that starts the next frame,
        // so a blanked frame is dark from its first cycle.
        fcnt_d  = '0;
        phase_d = 1'b0;
        if (bus.en && bus.blink) begin
            fcnt_d  = fcnt_q;
            phase_d = phase_q;
            if (frame_evt) begin
                if (fcnt_q == FLAST) begin
                    fcnt_d  = '0;
                    phase_d = ~phase_q;
                end else begin
                    fcnt_d = fcnt_q + FW'(1);
                end
            end
        end

        // sel only moves when entering a blanked state.
        sel_d = sel_q;
        case (state_d)
            ST_GAP0:          sel_d = 1'b1;
            ST_GAP1, ST_IDLE: sel_d = 1'b0;
            default:          sel_d = sel_q;
        endcase

        an_d = (bus.blink && phase_d) ? AN_OFF : an_for_state(state_d);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            dcnt_q  <= '0;
            fcnt_q  <= '0;
            phase_q <= 1'b0;
            sel_q   <= 1'b0;
            an_q    <= AN_OFF;
            fd_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dcnt_q  <= dcnt_d;
            fcnt_q  <= fcnt_d;
            phase_q <= phase_d;
            sel_q   <= sel_d;
            an_q    <= an_d;
            fd_q    <= frame_evt;
            busy_q  <= (state_d != ST_IDLE);
        end
    end

    assign bus.sel        = sel_q;
    assign bus.an         = an_q;
    assign bus.frame_done = fd_q;
    assign bus.busy       = busy_q;
endmodule

// File: tb/tb_seg_scan_scheduler.sv
// Bench for seg_scan_scheduler (TICK_DIV=4, DIGIT_TICKS=2, BLINK_FRAMES=2).
// A position-in-frame model predicts every output cycle; a monitor compares.
module tb_seg_scan_scheduler;
    import seg_scan_scheduler_pkg::*;

    localparam int unsigned TD = 4;
    localparam int unsigned DT = 2;
    localparam int unsigned BF = 2;
    localparam int SHOW_C = DT * TD;
    localparam int GAP_C  = TD;
    localparam int FRAME  = 2 * SHOW_C + 2 * GAP_C;

    typedef struct packed {
        logic [1:0] an;
        logic       sel;
        logic       fd;
        logic       busy;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   fd_count = 0;
    int   run = -1;   // cycles since the run started, -1 when idle
    int   bfr = 0;    // frame boundaries passed with blink held high
    exp_t q[$];

    seg_scan_scheduler_if bus ();

    seg_scan_scheduler #(
        .TICK_DIV     (TD),
        .DIGIT_TICKS  (DT),
        .BLINK_FRAMES (BF)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [1:0] act, input logic [1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    function automatic exp_t idle_exp();
        exp_t x;
        x.an = 2'b11; x.sel = 1'b0; x.fd = 1'b0; x.busy = 1'b0;
        return x;
    endfunction

    function automatic exp_t predict(input logic b);
        exp_t x;
        int   p;
        x = idle_exp();
        if (run >= 0) begin
            p      = run % FRAME;
            x.busy = 1'b1;
            x.fd   = (run > 0 && p == 0);
            x.sel  = (p >= SHOW_C && p < 2 * SHOW_C + GAP_C);
            if (p < SHOW_C)                   x.an = 2'b10;
            else if (p < SHOW_C + GAP_C)      x.an = 2'b11;
            else if (p < 2 * SHOW_C + GAP_C)  x.an = 2'b01;
            else                              x.an = 2'b11;
            if (b && ((bfr / BF) % 2 == 1))   x.an = 2'b11;
        end
        return x;
    endfunction

    // Model of one clock edge, given the inputs sampled at that edge.
    task automatic model_edge(input logic r, input logic e, input logic b);
        if (r || !e) begin
            run = -1;
            bfr = 0;
        end else begin
            run = (run < 0) ? 0 : run + 1;
            if (!b) bfr = 0;
            else if (run > 0 && run % FRAME == 0) bfr++;
        end
        q.push_back(predict(b));
    endtask

    task automatic step(input logic r, input logic e, input logic b);
        rst = r;
        bus.en = e;
        bus.blink = b;
        @(posedge clk);
        model_edge(r, e, b);
        #1;
    endtask

    // Raise reset between edges; outputs must clear without a clock.
    task automatic async_reset();
        #1;
        rst = 1'b1;
        #1;
        chk("async_rst_an", bus.an, 2'b11);
        chk("async_rst_sel", {1'b0, bus.sel}, 2'b00);
        chk("async_rst_busy", {1'b0, bus.busy}, 2'b00);
        chk("async_rst_fd", {1'b0, bus.frame_done}, 2'b00);
        q.delete();
        run = -1;
        bfr = 0;
        q.push_back(idle_exp());
    endtask

    initial begin : monitor
        exp_t e;
        logic sel_prev;
        sel_prev = 1'b0;
        forever begin
            @(negedge clk);
            chk("an_not_00", {1'b0, bus.an == 2'b00}, 2'b00);
            if (bus.sel !== sel_prev)
                chk("sel_moves_blanked", bus.an, 2'b11);
            sel_prev = bus.sel;
            if (bus.frame_done === 1'b1) fd_count++;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("an", bus.an, e.an);
                chk("sel", {1'b0, bus.sel}, {1'b0, e.sel});
                chk("frame_done", {1'b0, bus.frame_done}, {1'b0, e.fd});
                chk("busy", {1'b0, bus.busy}, {1'b0, e.busy});
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : driver
        logic e_r;
        logic b_r;
        bus.en = 1'b0;
        bus.blink = 1'b0;
        #1;
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);

        // Plain first frame and the start of the second.
        step(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 30; i++) step(1'b0, 1'b1, 1'b0);

        // en dropped in SHOW1 (cycle 16), then restart.
        step(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 12; i++) step(1'b0, 1'b1, 1'b0);

        // Blink over six frames; six frame_done pulses expected.
        step(1'b0, 1'b0, 1'b1);
        @(negedge clk);
        #1;
        fd_count = 0;
        for (int i = 0; i < 6 * FRAME + 1; i++) step(1'b0, 1'b1, 1'b1);
        @(negedge clk);
        #1;
        chk("blink_fd_count", 2'(fd_count == 6), 2'b01);
        step(1'b0, 1'b0, 1'b0);

        // Async reset in GAP0 (cycle 10), then the first-frame timing again.
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b0);
        async_reset();
        step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 30; i++) step(1'b0, 1'b1, 1'b0);

        // Random traffic: rare short en drops, slowly toggling blink.
        b_r = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            e_r = ($urandom_range(0, 299) != 0);
            if ($urandom_range(0, 199) == 0) b_r = ~b_r;
            step(1'b0, e_r, b_r);
        end

        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        chk("queue_drained", 2'(q.size() == 0), 2'b01);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
